// File: rtl/qpu_exu_wbck_arb_pkg.sv
// Shared defaults, priority-state encoding and a small helper for the
// QPU writeback arbiter.
package qpu_exu_wbck_arb_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int RFIDX_W_DEF    = 5;
  localparam int QUBIT_NUM_DEF  = 8;
  localparam int STARVE_MAX_DEF = 4;

  // Wide enough for any STARVE_MAX in 1..15
  localparam int STARVE_W = 4;

  typedef enum logic {
    ALU_PRI = 1'b0,
    LNG_PRI = 1'b1
  } prioState_e;

  // Saturating increment of the starvation counter
  function automatic logic [STARVE_W-1:0] satInc(input logic [STARVE_W-1:0] cnt,
                                                 input logic [STARVE_W-1:0] maxVal);
    if (cnt >= maxVal) begin
      return maxVal;
    end
    return cnt + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/qpu_exu_wbck_arb_prio_fsm.sv
// Priority FSM for the shared regfile write port. Picks the winner between
// the ALU and a regfile-writing long-pipe result, and flips priority to the
// long pipe once the ALU has won STARVE_MAX conflicts in a row.
module qpu_wbck_prio_fsm
  import qpu_exu_wbck_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic aluReq_i,
  input  logic lngReq_i,
  output logic aluGnt_o,
  output logic lngGnt_o
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  prioState_e          state_q;
  prioState_e          state_d;
  logic [STARVE_W-1:0] starveCnt_q;
  logic [STARVE_W-1:0] starveCnt_d;
  logic                conflict;
  logic                aluGnt;
  logic                lngGnt;

  assign conflict = aluReq_i & lngReq_i;

  // Holds the current priority state; reset is synchronous and active-high
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ALU_PRI;
    end else begin
      state_q <= state_d;
    end
  end

  // Moves to long-pipe priority the cycle the counter reaches its limit,
  // so the long pipe wins the very next conflict
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALU_PRI: if (starveCnt_d == STARVE_LIM) state_d = LNG_PRI;
      LNG_PRI: if (lngGnt) state_d = ALU_PRI;
      default: state_d = ALU_PRI;
    endcase
  end

  // Grants: a lone requester always wins, a conflict goes by priority state
  always_comb begin
    aluGnt = 1'b0;
    lngGnt = 1'b0;
    if (conflict) begin
      aluGnt = (state_q == ALU_PRI);
      lngGnt = (state_q == LNG_PRI);
    end else begin
      aluGnt = aluReq_i;
      lngGnt = lngReq_i;
    end
  end

  // Counts conflicts the ALU wins; any long-pipe grant clears it
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (conflict && aluGnt) begin
      starveCnt_d = satInc(starveCnt_q, STARVE_LIM);
    end else if (lngGnt) begin
      starveCnt_d = '0;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end

  assign aluGnt_o = aluGnt;
  assign lngGnt_o = lngGnt;

endmodule

// File: rtl/qpu_exu_wbck_arb.sv
// Writeback arbiter and retire sequencer for the QPU execution unit.
// Shares the regfile write port between ALU and long pipe, retires OITF
// entries in order, and writes measurement results into the qubit-result
// file while retiring the measure-FIFO head.
// Optional build macro QPU_WBCK_ERR_EN adds a sticky wbck_err output.
module qpu_exu_wbck_arb
  import qpu_exu_wbck_arb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int RFIDX_W    = RFIDX_W_DEF,
  parameter int QUBIT_NUM  = QUBIT_NUM_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_wbck_i_valid,
  output logic                 alu_wbck_i_ready,
  input  logic [XLEN-1:0]      alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]   alu_wbck_i_rdidx,
  input  logic                 lng_wbck_i_valid,
  output logic                 lng_wbck_i_ready,
  input  logic [XLEN-1:0]      lng_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]   oitf_ret_rdidx,
  input  logic                 oitf_ret_rdwen,
  input  logic                 oitf_empty,
  output logic                 oitf_ret_cl_ena,
  input  logic                 mcu_res_valid,
  output logic                 mcu_res_ready,
  input  logic [QUBIT_NUM-1:0] mcu_res_data,
  input  logic [QUBIT_NUM-1:0] moitf_ret_mf,
  input  logic                 moitf_empty,
  output logic                 oitf_ret_qf_ena,
  output logic                 rf_wbck_ena,
  output logic [RFIDX_W-1:0]   rf_wbck_rdidx,
  output logic [XLEN-1:0]      rf_wbck_wdat,
  output logic                 qr_wbck_ena,
  output logic [QUBIT_NUM-1:0] qr_wbck_mask,
  output logic [QUBIT_NUM-1:0] qr_wbck_data
`ifdef QPU_WBCK_ERR_EN
  ,
  output logic                 wbck_err
`endif
);

  logic lngOk;
  logic lngNowr;
  logic lngWrReq;
  logic aluGnt;
  logic lngWrGnt;
  logic aluAcc;
  logic lngWrAcc;
  logic lngNowrAcc;
  logic mcuAcc;

  logic                 rfEna_q;
  logic                 rfEna_d;
  logic [RFIDX_W-1:0]   rfIdx_q;
  logic [RFIDX_W-1:0]   rfIdx_d;
  logic [XLEN-1:0]      rfDat_q;
  logic [XLEN-1:0]      rfDat_d;
  logic                 qrEna_q;
  logic                 qrEna_d;
  logic [QUBIT_NUM-1:0] qrMask_q;
  logic [QUBIT_NUM-1:0] qrMask_d;
  logic [QUBIT_NUM-1:0] qrDat_q;
  logic [QUBIT_NUM-1:0] qrDat_d;

  // A long-pipe result only counts when the OITF actually holds its entry
  assign lngOk    = lng_wbck_i_valid & ~oitf_empty;
  assign lngNowr  = lngOk & ~oitf_ret_rdwen;
  assign lngWrReq = lngOk & oitf_ret_rdwen;

  qpu_wbck_prio_fsm #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .aluReq_i (alu_wbck_i_valid),
    .lngReq_i (lngWrReq),
    .aluGnt_o (aluGnt),
    .lngGnt_o (lngWrGnt)
  );

  // Handshakes are suppressed while reset is held so nothing retires then
  always_comb begin
    aluAcc     = aluGnt & ~rst_n;
    lngWrAcc   = lngWrGnt & ~rst_n;
    lngNowrAcc = lngNowr & ~rst_n;
    mcuAcc     = mcu_res_valid & ~moitf_empty & ~rst_n;
  end

  assign alu_wbck_i_ready = aluAcc;
  assign lng_wbck_i_ready = lngWrAcc | lngNowrAcc;
  assign oitf_ret_cl_ena  = lngWrAcc | lngNowrAcc;
  assign mcu_res_ready    = ~moitf_empty & ~rst_n;
  assign oitf_ret_qf_ena  = mcuAcc;

  // Selects the regfile write for next cycle from whichever source won
  always_comb begin
    rfEna_d = aluAcc | lngWrAcc;
    rfIdx_d = rfIdx_q;
    rfDat_d = rfDat_q;
    if (aluAcc) begin
      rfIdx_d = alu_wbck_i_rdidx;
      rfDat_d = alu_wbck_i_wdat;
    end else if (lngWrAcc) begin
      rfIdx_d = oitf_ret_rdidx;
      rfDat_d = lng_wbck_i_wdat;
    end
  end

  // Registered regfile write port; reset drops any pending write
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rfEna_q <= 1'b0;
      rfIdx_q <= '0;
      rfDat_q <= '0;
    end else begin
      rfEna_q <= rfEna_d;
      rfIdx_q <= rfIdx_d;
      rfDat_q <= rfDat_d;
    end
  end

  // Captures the measurement result masked by the FIFO head's qubit set
  always_comb begin
    qrEna_d  = mcuAcc;
    qrMask_d = qrMask_q;
    qrDat_d  = qrDat_q;
    if (mcuAcc) begin
      qrMask_d = moitf_ret_mf;
      qrDat_d  = mcu_res_data & moitf_ret_mf;
    end
  end

  // One-entry result buffer feeding the qubit-result file
  always_ff @(posedge clk) begin
    if (rst_n) begin
      qrEna_q  <= 1'b0;
      qrMask_q <= '0;
      qrDat_q  <= '0;
    end else begin
      qrEna_q  <= qrEna_d;
      qrMask_q <= qrMask_d;
      qrDat_q  <= qrDat_d;
    end
  end

  assign rf_wbck_ena   = rfEna_q;
  assign rf_wbck_rdidx = rfIdx_q;
  assign rf_wbck_wdat  = rfDat_q;
  assign qr_wbck_ena   = qrEna_q;
  assign qr_wbck_mask  = qrMask_q;
  assign qr_wbck_data  = qrDat_q;

`ifdef QPU_WBCK_ERR_EN
  logic errSet;
  logic err_q;

  assign errSet = (lng_wbck_i_valid & oitf_empty)
                | (mcu_res_valid & moitf_empty)
                | (oitf_ret_cl_ena & oitf_empty);

  // Sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_q <= 1'b0;
    end else if (errSet) begin
      err_q <= 1'b1;
    end
  end

  assign wbck_err = err_q;
`endif

endmodule

// File: tb/tb_qpu_exu_wbck_arb.sv
// Self-checking bench for qpu_exu_wbck_arb: a vector table for single-cycle
// behaviour plus hand sequences for starvation and mid-operation reset.
// Registered writes are predicted into scoreboard queues and popped when due.
module tb_qpu_exu_wbck_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wbck_i_valid;
  logic        alu_wbck_i_ready;
  logic [31:0] alu_wbck_i_wdat;
  logic [4:0]  alu_wbck_i_rdidx;
  logic        lng_wbck_i_valid;
  logic        lng_wbck_i_ready;
  logic [31:0] lng_wbck_i_wdat;
  logic [4:0]  oitf_ret_rdidx;
  logic        oitf_ret_rdwen;
  logic        oitf_empty;
  logic        oitf_ret_cl_ena;
  logic        mcu_res_valid;
  logic        mcu_res_ready;
  logic [7:0]  mcu_res_data;
  logic [7:0]  moitf_ret_mf;
  logic        moitf_empty;
  logic        oitf_ret_qf_ena;
  logic        rf_wbck_ena;
  logic [4:0]  rf_wbck_rdidx;
  logic [31:0] rf_wbck_wdat;
  logic        qr_wbck_ena;
  logic [7:0]  qr_wbck_mask;
  logic [7:0]  qr_wbck_data;
`ifdef QPU_WBCK_ERR_EN
  logic        wbck_err;
`endif

  qpu_exu_wbck_arb dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_wbck_i_valid (alu_wbck_i_valid),
    .alu_wbck_i_ready (alu_wbck_i_ready),
    .alu_wbck_i_wdat  (alu_wbck_i_wdat),
    .alu_wbck_i_rdidx (alu_wbck_i_rdidx),
    .lng_wbck_i_valid (lng_wbck_i_valid),
    .lng_wbck_i_ready (lng_wbck_i_ready),
    .lng_wbck_i_wdat  (lng_wbck_i_wdat),
    .oitf_ret_rdidx   (oitf_ret_rdidx),
    .oitf_ret_rdwen   (oitf_ret_rdwen),
    .oitf_empty       (oitf_empty),
    .oitf_ret_cl_ena  (oitf_ret_cl_ena),
    .mcu_res_valid    (mcu_res_valid),
    .mcu_res_ready    (mcu_res_ready),
    .mcu_res_data     (mcu_res_data),
    .moitf_ret_mf     (moitf_ret_mf),
    .moitf_empty      (moitf_empty),
    .oitf_ret_qf_ena  (oitf_ret_qf_ena),
    .rf_wbck_ena      (rf_wbck_ena),
    .rf_wbck_rdidx    (rf_wbck_rdidx),
    .rf_wbck_wdat     (rf_wbck_wdat),
    .qr_wbck_ena      (qr_wbck_ena),
    .qr_wbck_mask     (qr_wbck_mask),
    .qr_wbck_data     (qr_wbck_data)
`ifdef QPU_WBCK_ERR_EN
    ,
    .wbck_err         (wbck_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        aluV;
    logic [4:0]  aluIdx;
    logic [31:0] aluDat;
    logic        lngV;
    logic [31:0] lngDat;
    logic [4:0]  retIdx;
    logic        rdwen;
    logic        oEmpty;
    logic        mcuV;
    logic [7:0]  mcuDat;
    logic [7:0]  mf;
    logic        mEmpty;
    logic        expAluRdy;
    logic        expLngRdy;
    logic        expCl;
    logic        expMcuRdy;
    logic        expQf;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] dat;
  } rfExp_t;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] dat;
  } qrExp_t;

  rfExp_t rfQ[$];
  qrExp_t qrQ[$];
  vec_t   table_v[7];
  int     errors = 0;
  int     checks = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t idleVec();
    vec_t v;
    v = '{default: '0};
    v.oEmpty = 1'b1;
    v.mEmpty = 1'b1;
    return v;
  endfunction

  // Drives one cycle of inputs at the falling edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n            = v.rst;
    alu_wbck_i_valid = v.aluV;
    alu_wbck_i_rdidx = v.aluIdx;
    alu_wbck_i_wdat  = v.aluDat;
    lng_wbck_i_valid = v.lngV;
    lng_wbck_i_wdat  = v.lngDat;
    oitf_ret_rdidx   = v.retIdx;
    oitf_ret_rdwen   = v.rdwen;
    oitf_empty       = v.oEmpty;
    mcu_res_valid    = v.mcuV;
    mcu_res_data     = v.mcuDat;
    moitf_ret_mf     = v.mf;
    moitf_empty      = v.mEmpty;
  endtask

  // Checks same-cycle handshakes and predicts next-cycle writes
  task automatic checkOutput(input string tag, input vec_t v);
    rfExp_t r;
    qrExp_t q;
    #1;
    checkVal({tag, ".aluRdy"}, 32'(alu_wbck_i_ready), 32'(v.expAluRdy));
    checkVal({tag, ".lngRdy"}, 32'(lng_wbck_i_ready), 32'(v.expLngRdy));
    checkVal({tag, ".clEna"},  32'(oitf_ret_cl_ena),  32'(v.expCl));
    checkVal({tag, ".mcuRdy"}, 32'(mcu_res_ready),    32'(v.expMcuRdy));
    checkVal({tag, ".qfEna"},  32'(oitf_ret_qf_ena),  32'(v.expQf));
    if (v.expAluRdy) begin
      r.idx = v.aluIdx;
      r.dat = v.aluDat;
      rfQ.push_back(r);
    end else if (v.expLngRdy && v.rdwen) begin
      r.idx = v.retIdx;
      r.dat = v.lngDat;
      rfQ.push_back(r);
    end
    if (v.expQf) begin
      q.mask = v.mf;
      q.dat  = v.mcuDat & v.mf;
      qrQ.push_back(q);
    end
  endtask

  // After the rising edge, pops predicted writes and compares them
  task automatic checkRegistered(input string tag);
    rfExp_t r;
    qrExp_t q;
    @(posedge clk);
    #1;
    if (rfQ.size() > 0) begin
      r = rfQ.pop_front();
      checkVal({tag, ".rfEna"}, 32'(rf_wbck_ena), 32'd1);
      checkVal({tag, ".rfIdx"}, 32'(rf_wbck_rdidx), 32'(r.idx));
      checkVal({tag, ".rfDat"}, rf_wbck_wdat, r.dat);
    end else begin
      checkVal({tag, ".rfEna"}, 32'(rf_wbck_ena), 32'd0);
    end
    if (qrQ.size() > 0) begin
      q = qrQ.pop_front();
      checkVal({tag, ".qrEna"},  32'(qr_wbck_ena), 32'd1);
      checkVal({tag, ".qrMask"}, 32'(qr_wbck_mask), 32'(q.mask));
      checkVal({tag, ".qrDat"},  32'(qr_wbck_data), 32'(q.dat));
    end else begin
      checkVal({tag, ".qrEna"}, 32'(qr_wbck_ena), 32'd0);
    end
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
    checkRegistered(tag);
  endtask

  // ALU and a regfile-writing long pipe both request every cycle
  task automatic runStarvation(input string tag, input int n, input int lngWinAt);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = idleVec();
      v.aluV      = 1'b1;
      v.aluIdx    = 5'(10 + i);
      v.aluDat    = 32'h100 + 32'(i);
      v.lngV      = 1'b1;
      v.lngDat    = 32'hBEEF;
      v.retIdx    = 5'd20;
      v.rdwen     = 1'b1;
      v.oEmpty    = 1'b0;
      v.expAluRdy = (i != lngWinAt);
      v.expLngRdy = (i == lngWinAt);
      v.expCl     = (i == lngWinAt);
      runVec($sformatf("%s%0d", tag, i), v);
    end
  endtask

  initial begin
    vec_t v;

    // Table: single-cycle scenarios applied back to back
    v = idleVec(); v.aluV = 1; v.aluIdx = 3; v.aluDat = 32'hA5;
    v.expAluRdy = 1;
    table_v[0] = v;
    v = idleVec(); v.lngV = 1; v.lngDat = 32'h1234; v.retIdx = 7; v.rdwen = 1; v.oEmpty = 0;
    v.expLngRdy = 1; v.expCl = 1;
    table_v[1] = v;
    v = idleVec(); v.aluV = 1; v.aluIdx = 9; v.aluDat = 32'h55;
    v.lngV = 1; v.lngDat = 32'hDEAD; v.retIdx = 12; v.rdwen = 0; v.oEmpty = 0;
    v.expAluRdy = 1; v.expLngRdy = 1; v.expCl = 1;
    table_v[2] = v;
    v = idleVec(); v.mcuV = 1; v.mcuDat = 8'hFF; v.mf = 8'h05; v.mEmpty = 0;
    v.expMcuRdy = 1; v.expQf = 1;
    table_v[3] = v;
    v = idleVec(); v.lngV = 1; v.lngDat = 32'h77; v.retIdx = 4; v.rdwen = 1; v.oEmpty = 1;
    v.mcuV = 1; v.mcuDat = 8'hAA; v.mf = 8'hFF; v.mEmpty = 1;
    table_v[4] = v;
    v = idleVec(); v.aluV = 1; v.aluIdx = 1; v.aluDat = 32'h11;
    v.mcuV = 1; v.mcuDat = 8'h3C; v.mf = 8'hF0; v.mEmpty = 0;
    v.expAluRdy = 1; v.expMcuRdy = 1; v.expQf = 1;
    table_v[5] = v;
    v = idleVec(); v.mcuV = 1; v.mcuDat = 8'h01; v.mf = 8'h81; v.mEmpty = 0;
    v.expMcuRdy = 1; v.expQf = 1;
    table_v[6] = v;

    v = idleVec();
    v.rst = 1'b1;
    applyStimulus(v);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkVal("rst.rfEna",  32'(rf_wbck_ena), 32'd0);
    checkVal("rst.rfIdx",  32'(rf_wbck_rdidx), 32'd0);
    checkVal("rst.rfDat",  rf_wbck_wdat, 32'd0);
    checkVal("rst.qrEna",  32'(qr_wbck_ena), 32'd0);
    checkVal("rst.qrMask", 32'(qr_wbck_mask), 32'd0);
    checkVal("rst.qrDat",  32'(qr_wbck_data), 32'd0);
`ifdef QPU_WBCK_ERR_EN
    checkVal("rst.err", 32'(wbck_err), 32'd0);
`endif

    for (int i = 0; i < 7; i++) begin
      runVec($sformatf("vec%0d", i), table_v[i]);
    end
`ifdef QPU_WBCK_ERR_EN
    checkVal("errSticky", 32'(wbck_err), 32'd1);
`endif

    // Four ALU wins, long pipe on the fifth, ALU again afterwards
    runStarvation("starve", 7, 4);

    // Reset held while requests are valid: no handshakes, no writes
    v = idleVec();
    v.rst = 1; v.aluV = 1; v.aluIdx = 2; v.aluDat = 32'h99;
    v.lngV = 1; v.lngDat = 32'h66; v.retIdx = 5; v.rdwen = 1; v.oEmpty = 0;
    v.mcuV = 1; v.mcuDat = 8'hFF; v.mf = 8'hFF; v.mEmpty = 0;
    runVec("midRst", v);
    checkVal("midRst.rfIdx", 32'(rf_wbck_rdidx), 32'd0);
`ifdef QPU_WBCK_ERR_EN
    checkVal("midRst.err", 32'(wbck_err), 32'd0);
`endif

    // Counter must restart from zero after reset
    runStarvation("postRst", 6, 4);

    runVec("idle", idleVec());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qpu_exu_wbck_arb.md
Name: qpu_exu_wbck_arb

Overview:
Writeback arbiter and retire sequencer for the QPU execution unit. It shares the single classical regfile write port between the ALU and the long-pipe (OITF-tracked) writeback, and generates in-order retire strobes into the OITF. It also sequences measurement results from the measurement control unit (MCU) into the qubit-result register file and retires the matching measurement FIFO entry. It sits between the EXU units, the OITF and the regfile / qubit-result file.

Parameters:
XLEN, 32, classical data width
RFIDX_W, 5, regfile index width
QUBIT_NUM, 8, qubit count (mask/result width)
STARVE_MAX, 4, consecutive ALU wins tolerated while long-pipe pending (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-high (port name kept per codebase)
alu_wbck_i_valid  in  1  ALU result valid
alu_wbck_i_ready  out  1  ALU result accepted
alu_wbck_i_wdat  in  XLEN  ALU result
alu_wbck_i_rdidx  in  RFIDX_W  ALU destination
lng_wbck_i_valid  in  1  long-pipe result valid (always oldest OITF entry)
lng_wbck_i_ready  out  1  long-pipe result accepted
lng_wbck_i_wdat  in  XLEN  long-pipe result
oitf_ret_rdidx  in  RFIDX_W  destination of the OITF head entry
oitf_ret_rdwen  in  1  OITF head entry writes the regfile
oitf_empty  in  1  OITF has no outstanding entry
oitf_ret_cl_ena  out  1  retire the OITF head (pulse)
mcu_res_valid  in  1  measurement result valid
mcu_res_ready  out  1  measurement result accepted
mcu_res_data  in  QUBIT_NUM  measured bit values
moitf_ret_mf  in  QUBIT_NUM  qubit mask at the measure-FIFO head
moitf_empty  in  1  measure FIFO has no outstanding entry
oitf_ret_qf_ena  out  1  retire the measure-FIFO head (pulse)
rf_wbck_ena  out  1  regfile write enable (registered)
rf_wbck_rdidx  out  RFIDX_W  regfile write index (registered)
rf_wbck_wdat  out  XLEN  regfile write data (registered)
qr_wbck_ena  out  1  qubit-result write enable (registered)
qr_wbck_mask  out  QUBIT_NUM  qubits written (registered)
qr_wbck_data  out  QUBIT_NUM  result bits (registered)

Behaviour:
- Reset: all registered outputs 0; FSM in ALU_PRI; starve_cnt = 0; result buffer empty.
- Classical FSM, 2 states:
  - ALU_PRI: ALU wins conflicts.
  - LNG_PRI: long-pipe wins conflicts.
- lng_ok = lng_wbck_i_valid & ~oitf_empty. While oitf_empty=1, lng_wbck_i_ready = 0.
- lng_nowr = lng_ok & ~oitf_ret_rdwen:
  - lng_wbck_i_ready = 1 the same cycle, independent of ALU.
  - oitf_ret_cl_ena = 1; no port use.
  - starve_cnt is unchanged.
- Port conflict occurs when alu_wbck_i_valid and (lng_ok & oitf_ret_rdwen) are both set.
  - The winner is chosen by FSM state.
  - With no conflict, any single requester is granted.
- Ready signals and oitf_ret_cl_ena are combinational from the valids.
- Acceptance occurs when valid & ready.
- starve_cnt:
  - +1 on each conflict cycle the ALU wins.
  - Cleared on any long-pipe grant.
  - Saturates at STARVE_MAX.
- ALU_PRI -> LNG_PRI when starve_cnt == STARVE_MAX.
- LNG_PRI -> ALU_PRI after the next long-pipe grant.
- Granted write is registered. rf_wbck_* is valid exactly 1 cycle after acceptance, with rf_wbck_rdidx = alu idx or oitf_ret_rdidx.
- Measurement path, one-entry buffer:
  - mcu_res_ready = ~moitf_empty.
  - On acceptance, oitf_ret_qf_ena pulses the same cycle.
  - Next cycle: qr_wbck_ena = 1, qr_wbck_mask = moitf_ret_mf, qr_wbck_data = mcu_res_data & moitf_ret_mf (captured at acceptance).
  - Back-to-back acceptance is supported, one result per cycle.
- Measurement and classical paths are fully independent; simultaneous events on both paths in one cycle are legal.
- Reset asserted mid-operation drops any pending registered write; no strobe is emitted in the reset cycle.

Optional Feature:
QPU_WBCK_ERR_EN defined:
- Adds output wbck_err (1 bit, sticky until reset).
- Set when lng_wbck_i_valid & oitf_empty, or mcu_res_valid & moitf_empty.
- Set when oitf_ret_cl_ena and oitf_empty=1 coincide (internal assertion).
Undefined:
- No wbck_err port.
- Illegal requests are silently stalled (ready=0).

Decomposition:
- Shared defines: XLEN, RFIDX_W, QUBIT_NUM, STARVE_MAX defaults; FSM state encodings ALU_PRI=1'b0, LNG_PRI=1'b1.
- Registers use the gnrl dff library.
- One natural sub-module, qpu_wbck_prio_fsm: FSM plus starve counter, emitting the grant selects.

Test Plan:
- ALU only, idx 3, data 0xA5 -> ALU ready same cycle; rf_wbck_ena=1, idx 3, data 0xA5 next cycle; no retire strobe.
- Long-pipe with oitf_ret_rdwen=1, rdidx 7, data 0x1234, ALU idle -> lng ready + oitf_ret_cl_ena same cycle; rf write idx 7 data 0x1234 next cycle.
- Continuous ALU plus pending long-pipe, STARVE_MAX=4 -> ALU wins 4 cycles; long-pipe granted on the 5th; ALU wins again on the 6th.
- Long-pipe with rdwen=0 concurrent with ALU -> both ready the same cycle; oitf_ret_cl_ena=1; only the ALU write appears.
- moitf_ret_mf=0x05, mcu_res_data=0xFF, moitf_empty=0 -> mcu_res_ready=1 and oitf_ret_qf_ena pulse; next cycle qr_wbck mask 0x05, data 0x05.
- lng valid with oitf_empty=1, and mcu valid with moitf_empty=1 -> both readies 0, no strobes; with QPU_WBCK_ERR_EN, wbck_err=1 next cycle and held until reset.
